// File: rtl/constraint_stream_checker_pkg.sv
// Shared types for the constraint stream checker: opcodes, slot record, counter width.
// Slot fields are sized for the widest supported configuration (VAR_W <= 64, <= 256 vars).
package constraint_stream_pkg;

    localparam int CNT_W     = 32;
    localparam int CFG_IDX_W = 8;
    localparam int CFG_K_W   = 64;

    typedef enum logic [3:0] {
        OP_TRUE  = 4'd0,
        OP_NZ    = 4'd1,
        OP_NOTNZ = 4'd2,
        OP_LOR   = 4'd3,
        OP_NAND  = 4'd4,
        OP_MULNZ = 4'd5,
        OP_DIVNZ = 4'd6,
        OP_EQ    = 4'd7,
        OP_LTK   = 4'd8
    } op_e;

    // op kept as raw 4 bits so codes 9-15 can be stored and evaluate FALSE
    typedef struct packed {
        logic                 en;
        logic [3:0]           op;
        logic [CFG_IDX_W-1:0] a;
        logic [CFG_IDX_W-1:0] b;
        logic [CFG_K_W-1:0]   k;
    } cons_cfg_t;

endpackage

// File: rtl/constraint_eval.sv
// One constraint slot: selects operands from the variable vector and evaluates the opcode.
// Purely combinational; a disabled slot always reports TRUE.
module constraint_eval
    import constraint_stream_pkg::*;
#(
    parameter int NUM_VARS = 10,
    parameter int VAR_W    = 32
) (
    input  logic [NUM_VARS*VAR_W-1:0] vars,
    input  cons_cfg_t                 cfg,
    output logic                      res
);

    logic [VAR_W-1:0] a, b, k, prod;

    // Out-of-range operand indices fall through the mux and read as 0
    always_comb begin
        a = '0;
        b = '0;
        for (int v = 0; v < NUM_VARS; v++) begin
            if (32'(cfg.a) == v) a = vars[v*VAR_W +: VAR_W];
            if (32'(cfg.b) == v) b = vars[v*VAR_W +: VAR_W];
        end
    end

    assign k    = cfg.k[VAR_W-1:0];
    assign prod = (~a) * b;

    if (CFG_K_W > VAR_W) begin : g_k_pad
        logic unused_k_hi;
        assign unused_k_hi = ^cfg.k[CFG_K_W-1:VAR_W];
    end

    always_comb begin
        res = 1'b0;
        if (!cfg.en) begin
            res = 1'b1;
        end else begin
            case (cfg.op)
                OP_TRUE:  res = 1'b1;
                OP_NZ:    res = (a != '0);
                OP_NOTNZ: res = (~a != '0);
                OP_LOR:   res = (a != '0) || (b != '0);
                OP_NAND:  res = !((a != '0) && (b != '0));
                OP_MULNZ: res = (prod != '0);
                // floor(a/k) is nonzero exactly when a >= k, so no divider is needed
                OP_DIVNZ: res = (k != '0) && (a >= k);
                OP_EQ:    res = (a == b);
                OP_LTK:   res = (a < k);
                default:  res = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/constraint_stream_checker.sv
// Two-stage streaming constraint evaluator: programmable slot table, per-slot verdicts,
// fail mask with lowest-failing-slot encoder, and saturating verdict counters.
module constraint_stream_checker
    import constraint_stream_pkg::*;
#(
    parameter int NUM_VARS = 10,
    parameter int VAR_W    = 32,
    parameter int NUM_CONS = 8,
    parameter int IDX_W    = ($clog2((NUM_VARS > NUM_CONS) ? NUM_VARS : NUM_CONS) > 1)
                             ? $clog2((NUM_VARS > NUM_CONS) ? NUM_VARS : NUM_CONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic                      cfg_en,
    input  logic [3:0]                cfg_op,
    input  logic [IDX_W-1:0]          cfg_a,
    input  logic [IDX_W-1:0]          cfg_b,
    input  logic [VAR_W-1:0]          cfg_k,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_x,
    output logic [NUM_CONS-1:0]       out_fail_mask,
    output logic [IDX_W-1:0]          out_first_fail,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          cnt_total,
    output logic [CNT_W-1:0]          cnt_sat,
    output logic                      busy
);

    cons_cfg_t           tbl [NUM_CONS];
    logic [NUM_CONS-1:0] res_c, s1_res, fail_c;
    logic [2:1]          vld_pipe;
    logic                s1_adv, s2_adv, cfg_ok;
    logic [IDX_W-1:0]    first_c;

    assign out_valid = vld_pipe[2];
    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign busy      = |vld_pipe;
    // Table only changes with the pipe empty and nothing arriving, so no verdict mixes configs
    assign cfg_ok    = cfg_we && !busy && !in_valid && (32'(cfg_idx) < NUM_CONS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_CONS; j++) tbl[j] <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int j = 0; j < NUM_CONS; j++) begin
                if (cfg_ok && 32'(cfg_idx) == j)
                    tbl[j] <= '{en: cfg_en, op: cfg_op, a: CFG_IDX_W'(cfg_a),
                                b: CFG_IDX_W'(cfg_b), k: CFG_K_W'(cfg_k)};
            end
        end
    end

    for (genvar j = 0; j < NUM_CONS; j++) begin : g_slot
        constraint_eval #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W)) u_eval (
            .vars (in_vars),
            .cfg  (tbl[j]),
            .res  (res_c[j])
        );
    end

    assign fail_c = ~s1_res;

    always_comb begin
        first_c = '0;
        for (int j = NUM_CONS - 1; j >= 0; j--)
            if (fail_c[j]) first_c = IDX_W'(j);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe       <= '0;
            s1_res         <= '0;
            out_x          <= 1'b0;
            out_fail_mask  <= '0;
            out_first_fail <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_res <= res_c;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_x          <= &s1_res;
                    out_fail_mask  <= fail_c;
                    out_first_fail <= first_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total <= '0;
            cnt_sat   <= '0;
        end else if (cnt_clr) begin
            cnt_total <= '0;
            cnt_sat   <= '0;
        end else if (out_valid && out_ready) begin
            if (cnt_total != '1) cnt_total <= cnt_total + CNT_W'(1);
            if (out_x && cnt_sat != '1) cnt_sat <= cnt_sat + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_constraint_stream_checker.sv
// Randomized and directed bench for constraint_stream_checker against a queue-based verdict model.
module tb_constraint_stream_checker;
    import constraint_stream_pkg::*;

    localparam int NV = 10;
    localparam int VW = 32;
    localparam int NC = 8;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_we = 1'b0, cfg_en = 1'b0, cfg_err;
    logic [IW-1:0]     cfg_idx = '0, cfg_a = '0, cfg_b = '0;
    logic [3:0]        cfg_op = '0;
    logic [VW-1:0]     cfg_k = '0;
    logic              in_valid = 1'b0, in_ready;
    logic [NV*VW-1:0]  in_vars = '0;
    logic              out_valid, out_ready = 1'b1, out_x;
    logic [NC-1:0]     out_fail_mask;
    logic [IW-1:0]     out_first_fail;
    logic              cnt_clr = 1'b0, busy;
    logic [31:0]       cnt_total, cnt_sat;

    always #5 clk = ~clk;

    constraint_stream_checker #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_op(cfg_op),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_k(cfg_k), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_fail_mask(out_fail_mask), .out_first_fail(out_first_fail),
        .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_sat(cnt_sat), .busy(busy)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic          x;
        logic [NC-1:0] mask;
        int            first;
    } verdict_t;

    logic        m_en [NC];
    logic [3:0]  m_op [NC];
    int          m_a  [NC];
    int          m_b  [NC];
    logic [31:0] m_k  [NC];
    verdict_t    q[$];
    verdict_t    cur;
    logic [31:0] m_tot = 0, m_sat = 0;
    logic        err_pend = 1'b0;
    int          n_acc = 0;
    logic        stall_q = 1'b0, sv_valid, sv_x;
    logic [NC-1:0] sv_mask;
    logic [IW-1:0] sv_first;

    function automatic logic [31:0] opnd(input logic [NV*VW-1:0] v, input int i);
        if (i >= NV) return 32'd0;
        return v[i*VW +: VW];
    endfunction

    function automatic logic holds(input int j, input logic [NV*VW-1:0] v);
        logic [31:0] a, b, k, p;
        a = opnd(v, m_a[j]);
        b = opnd(v, m_b[j]);
        k = m_k[j];
        if (!m_en[j]) return 1'b1;
        case (m_op[j])
            4'd0: return 1'b1;
            4'd1: return a != 0;
            4'd2: return (~a) != 0;
            4'd3: return (a != 0) || (b != 0);
            4'd4: return !((a != 0) && (b != 0));
            4'd5: begin p = (~a) * b; return p != 0; end
            4'd6: begin if (k == 0) return 1'b0; return (a / k) != 0; end
            4'd7: return a == b;
            4'd8: return a < k;
            default: return 1'b0;
        endcase
    endfunction

    function automatic verdict_t predict(input logic [NV*VW-1:0] v);
        verdict_t r;
        r.mask = '0;
        r.first = 0;
        for (int j = 0; j < NC; j++) r.mask[j] = !holds(j, v);
        for (int j = NC - 1; j >= 0; j--) if (r.mask[j]) r.first = j;
        r.x = (r.mask == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            for (int j = 0; j < NC; j++) begin
                m_en[j] = 0; m_op[j] = 0; m_a[j] = 0; m_b[j] = 0; m_k[j] = 0;
            end
            m_tot = 0; m_sat = 0; err_pend = 0; stall_q = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_x", out_x, 0);
            chk("rst_mask", out_fail_mask, 0);
            chk("rst_first", out_first_fail, 0);
            chk("rst_cnt_total", cnt_total, 0);
            chk("rst_cnt_sat", cnt_sat, 0);
            chk("rst_cfg_err", cfg_err, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("busy", busy, q.size() > 0);
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            chk("cfg_err", cfg_err, err_pend);
            chk("cnt_total", cnt_total, m_tot);
            chk("cnt_sat", cnt_sat, m_sat);
            if (stall_q) begin
                chk("hold_valid", out_valid, sv_valid);
                chk("hold_x", out_x, sv_x);
                chk("hold_mask", out_fail_mask, sv_mask);
                chk("hold_first", out_first_fail, sv_first);
            end
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("out_x", out_x, q[0].x);
                    chk("out_mask", out_fail_mask, q[0].mask);
                    chk("out_first", out_first_fail, q[0].first);
                end
            end
            stall_q = out_valid && !out_ready;
            sv_valid = out_valid; sv_x = out_x; sv_mask = out_fail_mask; sv_first = out_first_fail;
            // advance model across the coming rising edge
            err_pend = 0;
            if (cfg_we) begin
                if (q.size() == 0 && !in_valid && int'(cfg_idx) < NC) begin
                    m_en[cfg_idx] = cfg_en; m_op[cfg_idx] = cfg_op;
                    m_a[cfg_idx] = int'(cfg_a); m_b[cfg_idx] = int'(cfg_b); m_k[cfg_idx] = cfg_k;
                end else err_pend = 1;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                cur = q.pop_front();
                if (m_tot != 32'hFFFF_FFFF) m_tot = m_tot + 1;
                if (cur.x && m_sat != 32'hFFFF_FFFF) m_sat = m_sat + 1;
            end
            if (cnt_clr) begin m_tot = 0; m_sat = 0; end
            if (in_valid && in_ready) begin
                q.push_back(predict(in_vars));
                n_acc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NV*VW-1:0] mkv(input logic [31:0] v1, input logic [31:0] v2);
        logic [NV*VW-1:0] r;
        r = '0;
        r[1*VW +: VW] = v1;
        r[2*VW +: VW] = v2;
        return r;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 8));
            4: return 32'($urandom_range(0, 3)) << 30;
            default: return $urandom;
        endcase
    endfunction

    task automatic cfg_wr(input int idx, input logic en, input int op, input int a, input int b,
                          input logic [31:0] k);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_en = en; cfg_op = 4'(op);
        cfg_a = IW'(a); cfg_b = IW'(b); cfg_k = k;
        step();
        cfg_we = 0;
    endtask

    // Assumes an idle pipeline: accept, check 2-cycle latency, check verdict, consume it.
    task automatic send_get(input logic [NV*VW-1:0] v, input logic ex, input logic [NC-1:0] em,
                            input int ef, input string nm);
        in_vars = v; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk({nm, "_lat1"}, out_valid, 0);
        step();
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_x"}, out_x, ex);
        chk({nm, "_mask"}, out_fail_mask, em);
        chk({nm, "_first"}, out_first_fail, ef);
        step();
    endtask

    initial begin
        int n0;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        step();
        send_get('0, 1, 8'h00, 0, "zeros");
        @(negedge clk);
        chk("first_cnt_total", cnt_total, 1);
        chk("first_cnt_sat", cnt_sat, 1);
        step();

        cfg_wr(3, 1, 6, 2, 0, 32'd4);
        send_get(mkv(0, 3), 0, 8'h08, 3, "divnz_3");
        send_get(mkv(0, 4), 1, 8'h00, 0, "divnz_4");
        cfg_wr(0, 1, 5, 1, 1, 32'd0);
        send_get(mkv(32'hFFFF_FFFF, 4), 0, 8'h01, 0, "mulnz_ff");
        send_get(mkv(5, 4), 1, 8'h00, 0, "mulnz_5");
        cfg_wr(5, 1, 6, 0, 0, 32'd0);
        send_get(mkv(5, 4), 0, 8'h20, 5, "divnz_k0");

        // backpressure: 4 back-to-back with out_ready low for 3 cycles
        n0 = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int w;
                    logic acc;
                    w = 0;
                    in_vars = mkv(32'(i * 3), 32'(i + 2));
                    in_valid = 1;
                    forever begin
                        @(negedge clk);
                        acc = in_ready;
                        step();
                        if (acc) break;
                        if (++w > 50) begin chk("bp_timeout", 1, 0); break; end
                    end
                end
                in_valid = 0;
            end
            begin
                out_ready = 0;
                repeat (3) step();
                chk("bp_accepts_stalled", n_acc - n0, 2);
                out_ready = 1;
            end
        join
        repeat (4) step();
        chk("bp_all_accepted", n_acc - n0, 4);
        chk("bp_drained", q.size(), 0);

        // config write while busy is dropped
        in_vars = mkv(5, 4); in_valid = 1;
        step();
        in_valid = 0;
        cfg_wr(6, 1, 9, 0, 0, 32'd0);
        @(negedge clk);
        chk("busy_cfg_err", cfg_err, 1);
        repeat (3) step();
        send_get(mkv(5, 4), 0, 8'h20, 5, "busy_table_kept");
        cfg_wr(9, 1, 9, 0, 0, 32'd0);
        @(negedge clk);
        chk("idx9_cfg_err", cfg_err, 1);
        step();
        cfg_wr(5, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("good_cfg_no_err", cfg_err, 0);
        step();

        // cnt_clr wins over a coincident handshake
        out_ready = 0; in_vars = mkv(5, 4); in_valid = 1;
        step();
        in_valid = 0;
        step();
        out_ready = 1; cnt_clr = 1;
        step();
        cnt_clr = 0;
        @(negedge clk);
        chk("clr_cnt_total", cnt_total, 0);
        chk("clr_cnt_sat", cnt_sat, 0);
        step();

        // saturation
        @(posedge clk);
        #2;
        force dut.cnt_total = 32'hFFFF_FFFF;
        force dut.cnt_sat = 32'hFFFF_FFFE;
        m_tot = 32'hFFFF_FFFF;
        m_sat = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_total;
        release dut.cnt_sat;
        send_get(mkv(5, 4), 1, 8'h00, 0, "sat_a");
        send_get(mkv(5, 4), 1, 8'h00, 0, "sat_b");
        @(negedge clk);
        chk("sat_total", cnt_total, 32'hFFFF_FFFF);
        chk("sat_sat", cnt_sat, 32'hFFFF_FFFF);
        step();

        // randomized traffic with config churn and idle gaps
        for (int c = 0; c < 2500; c++) begin
            logic [NV*VW-1:0] v;
            for (int i = 0; i < NV; i++) v[i*VW +: VW] = rv();
            in_vars = v;
            in_valid = ((c % 60) < 45) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 99) == 0);
            cfg_we = ($urandom_range(0, 4) == 0);
            cfg_idx = IW'($urandom_range(0, 9));
            cfg_en = ($urandom_range(0, 3) != 0);
            cfg_op = 4'($urandom_range(0, 10));
            cfg_a = IW'($urandom_range(0, 11));
            cfg_b = IW'($urandom_range(0, 11));
            cfg_k = rv();
            step();
        end
        cfg_we = 0; cnt_clr = 0;

        // reset mid-stream
        in_valid = 1; out_ready = 0;
        step();
        step();
        #2 rst_n = 0;
        step();
        step();
        in_valid = 0; out_ready = 1;
        rst_n = 1;
        step();
        send_get(mkv(0, 0), 1, 8'h00, 0, "post_reset_table");

        repeat (5) step();
        chk("final_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/constraint_stream_checker.md
# constraint_stream_checker

Pipelined, runtime-configurable constraint evaluator for the BDD-solver flow. Candidate variable assignments stream in over a valid/ready handshake. Each assignment is checked against up to NUM_CONS programmable constraint slots. A verdict leaves two cycles later with a per-slot fail mask. The block generalises the fixed single-assignment combinational checkers: slot contents are programmed at runtime, there is backpressure, and it keeps running satisfied/evaluated counts for the solver's sampling loop.

## Interface
Parameters:
- NUM_VARS, 10, number of packed input variables
- VAR_W, 32, width of every variable slot; narrower variables are zero-extended by the producer
- NUM_CONS, 8, number of constraint slots (≥2)
- IDX_W = max(1, $clog2(max(NUM_VARS, NUM_CONS))), derived index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write constraint slot
- cfg_idx  in  IDX_W  slot number
- cfg_en  in  1  slot enable
- cfg_op  in  4  opcode
- cfg_a / cfg_b  in  IDX_W each  operand variable indices
- cfg_k  in  VAR_W  constant operand
- cfg_err  out  1  one-cycle pulse: write rejected
- in_valid / in_ready  in / out  1  assignment handshake
- in_vars  in  NUM_VARS*VAR_W  variable i at bits [i*VAR_W +: VAR_W]
- out_valid / out_ready  out / in  1  verdict handshake
- out_x  out  1  all enabled slots satisfied
- out_fail_mask  out  NUM_CONS  bit j set when slot j is enabled and false
- out_first_fail  out  IDX_W  lowest set bit of fail mask; 0 when mask is 0
- cnt_clr  in  1  synchronous clear of counters
- cnt_total / cnt_sat  out  32  verdicts delivered / verdicts with out_x=1
- busy  out  1  any pipeline stage valid

## Operation
- Operands: a = var[cfg_a], b = var[cfg_b], k = cfg_k. All operations are VAR_W wide and unsigned.
- Opcodes:
  - 0 TRUE
  - 1 NZ: a≠0
  - 2 NOTNZ: ~a≠0
  - 3 LOR: a≠0 ∨ b≠0
  - 4 NAND: ¬(a≠0 ∧ b≠0)
  - 5 MULNZ: (~a·b) mod 2^VAR_W ≠0
  - 6 DIVNZ: k≠0 ∧ a/k≠0
  - 7 EQ: a==b
  - 8 LTK: a<k
  - 9–15 evaluate as FALSE.
- A disabled slot evaluates TRUE and never sets its fail-mask bit.
- Operand index ≥ NUM_VARS reads as 0. A cfg_idx ≥ NUM_CONS write is rejected with cfg_err.
- Config writes are accepted only when busy=0 and in_valid=0. Otherwise the write is dropped and cfg_err pulses the next cycle. An accepted write takes effect for assignments accepted on the following cycle or later.
- Reset: all slots disabled with op=0, a=b=0, k=0. An all-disabled table yields out_x=1.
- Counters increment on the out_valid∧out_ready handshake and saturate at 2^32−1. cnt_clr has priority: on a clear cycle both counters become 0 and that cycle's handshake is not counted.

## Timing
- Two stages:
  - S1 registers the per-slot result bits.
  - S2 registers out_x, out_fail_mask and out_first_fail.
- Latency is 2 cycles from in handshake to out_valid. Throughput is 1 per cycle while out_ready=1.
- Advance rules: s2_adv = ¬out_valid ∨ out_ready; s1_adv = ¬s1_valid ∨ s2_adv; in_ready = s1_adv. in_ready is combinational from out_ready.
- While stalled (out_valid=1, out_ready=0), all out_* signals hold stable.
- Reset values: out_valid=0, out_x=0, out_fail_mask=0, out_first_fail=0, cnt_total=0, cnt_sat=0, cfg_err=0, busy=0, S1 empty.
- Reset asserted mid-stream flushes both stages; in-flight verdicts are lost and the config table returns to its reset state.
- busy = s1_valid ∨ out_valid.

## Structure
- Package constraint_stream_pkg holds:
  - the opcode enum op_e (TRUE…LTK)
  - the slot record typedef cons_cfg_t {en, op, a, b, k}
  - the counter width constant CNT_W=32
- One sub-module, constraint_eval: purely combinational, one slot (cons_cfg_t plus the variable vector → 1-bit result), instantiated NUM_CONS times by generate.
- Top-level holds the config table, both pipeline stages, the priority encoder and the counters.

## Test plan
- Reset with defaults, send in_vars all zero with out_ready=1 → out_valid 2 cycles later, out_x=1, mask=0, cnt_total=1, cnt_sat=1.
- Program slot 3 = {en,DIVNZ,a=2,k=4}, drive var2=3 → out_x=0, mask=0x08, first_fail=3. Drive var2=4 → out_x=1.
- Program slot 0 = {en,MULNZ,a=1,b=1}, drive var1=0xFFFFFFFF → false. Drive var1=5 → true. Program slot 5 = {en,DIVNZ,k=0} → always false, mask bit 5.
- Stream 4 assignments back-to-back with out_ready held low for 3 cycles → in_ready drops after 2 accepts, outputs hold stable, and all 4 verdicts are delivered in order.
- Assert cfg_we while busy=1 → cfg_err pulses, table unchanged. Write cfg_idx=9 with NUM_CONS=8 → cfg_err.
- Preload cnt_total=0xFFFFFFFF via a long run (or force) → it stays saturated. cnt_clr coincident with a handshake → both counters read 0.
